// File: rtl/bolme_tanimlari.sv
// Shared definitions for the multi-cycle divider: opcodes and FSM states.
package bolme_tanimlari;

  // RV32M divide opcodes as presented on islem_kodu_i
  localparam logic [1:0] BOL_DIV  = 2'b00;
  localparam logic [1:0] BOL_DIVU = 2'b01;
  localparam logic [1:0] BOL_REM  = 2'b10;
  localparam logic [1:0] BOL_REMU = 2'b11;

  typedef enum logic [1:0] {
    BOSTA   = 2'b00,
    HESAPLA = 2'b01,
    DUZELT  = 2'b10,
    BITTI   = 2'b11
  } durum_t;

endpackage

// File: rtl/bolme_adimi.sv
// One restoring-division step on the {remainder, quotient} shift pair.
module bolme_adimi #(
  parameter int VERI_GENISLIGI = 32
) (
  input  logic [VERI_GENISLIGI:0]   kalan_g,
  input  logic [VERI_GENISLIGI-1:0] bolum_g,
  input  logic [VERI_GENISLIGI-1:0] bolen_g,
  output logic [VERI_GENISLIGI:0]   kalan_c,
  output logic [VERI_GENISLIGI-1:0] bolum_c
);

  localparam int W = VERI_GENISLIGI;

  logic [W+1:0] kaydirilmis;
  logic [W+1:0] fark;
  logic         bolum_biti;

  // Shift in the next dividend bit, trial-subtract, keep the difference if non-negative
  always_comb begin
    kaydirilmis = {kalan_g, bolum_g[W-1]};
    fark        = kaydirilmis - {2'b00, bolen_g};
    bolum_biti  = ~fark[W+1];
    kalan_c     = bolum_biti ? fark[W:0] : kaydirilmis[W:0];
    bolum_c     = {bolum_g[W-2:0], bolum_biti};
  end

endmodule

// File: rtl/bolme_birimi.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) with stall, flush and
// single-cycle handling of divide-by-zero and signed overflow.
module bolme_birimi
  import bolme_tanimlari::*;
#(
  parameter int VERI_GENISLIGI  = 32,
  parameter int ADIM_BASINA_BIT = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      durdur_i,
  input  logic                      iptal_i,
  input  logic                      blok_aktif_i,
  input  logic [1:0]                islem_kodu_i,
  input  logic [VERI_GENISLIGI-1:0] bolunen_i,
  input  logic [VERI_GENISLIGI-1:0] bolen_i,
  output logic                      mesgul_o,
  output logic                      sonuc_gecerli_o,
  output logic [VERI_GENISLIGI-1:0] sonuc_o
);

  localparam int W  = VERI_GENISLIGI;
  localparam int K  = ADIM_BASINA_BIT;
  localparam int N  = W / K;
  localparam int SW = $clog2(N);

  // Magnitude of an operand; the most-negative value maps to 2^(W-1) unsigned
  function automatic logic [W-1:0] mutlak(input logic [W-1:0] v, input logic isaretli);
    return (isaretli && v[W-1]) ? ({W{1'b0}} - v) : v;
  endfunction

  // Conditional two's-complement negation for the sign fix-up
  function automatic logic [W-1:0] isaret_uygula(input logic [W-1:0] v, input logic negatif);
    return negatif ? ({W{1'b0}} - v) : v;
  endfunction

  durum_t         durum, sonraki_durum;
  logic           sonraki_mesgul, sonraki_gecerli;
  logic [SW-1:0]  sayac;
  logic [W:0]     kalan_r;
  logic [W-1:0]   bolum_r;
  logic [W-1:0]   bolen_r;
  logic           kalan_sec_r, neg_bolum_r, neg_kalan_r;

  logic           isaretli, kalan_istek, sifir_bolen, tasma, hizli, kabul;
  logic [W-1:0]   hizli_sonuc;

  logic [K:0][W:0]   kalan_z;
  logic [K:0][W-1:0] bolum_z;

  // Decode the incoming request and pick the fast-path result
  always_comb begin
    isaretli    = (islem_kodu_i == BOL_DIV) || (islem_kodu_i == BOL_REM);
    kalan_istek = (islem_kodu_i == BOL_REM) || (islem_kodu_i == BOL_REMU);
    sifir_bolen = (bolen_i == '0);
    tasma       = isaretli && (bolunen_i == {1'b1, {(W-1){1'b0}}}) && (bolen_i == '1);
    hizli       = sifir_bolen || tasma;
    if (sifir_bolen) hizli_sonuc = kalan_istek ? bolunen_i : '1;
    else             hizli_sonuc = kalan_istek ? '0 : bolunen_i;
    kabul = ((durum == BOSTA) || (durum == BITTI)) && !durdur_i && !iptal_i && blok_aktif_i;
  end

  assign kalan_z[0] = kalan_r;
  assign bolum_z[0] = bolum_r;

  for (genvar i = 0; i < K; i++) begin : g_adim
    bolme_adimi #(.VERI_GENISLIGI(W)) u_adim (
      .kalan_g (kalan_z[i]),
      .bolum_g (bolum_z[i]),
      .bolen_g (bolen_r),
      .kalan_c (kalan_z[i+1]),
      .bolum_c (bolum_z[i+1])
    );
  end

  // Next state and registered handshake outputs; flush beats stall beats start
  always_comb begin
    sonraki_durum   = durum;
    sonraki_mesgul  = mesgul_o;
    sonraki_gecerli = sonuc_gecerli_o;
    if (iptal_i) begin
      sonraki_durum   = BOSTA;
      sonraki_mesgul  = 1'b0;
      sonraki_gecerli = 1'b0;
    end else if (!durdur_i) begin
      case (durum)
        BOSTA, BITTI: begin
          if (kabul && hizli) begin
            sonraki_durum   = BITTI;
            sonraki_mesgul  = 1'b0;
            sonraki_gecerli = 1'b1;
          end else if (kabul) begin
            sonraki_durum   = HESAPLA;
            sonraki_mesgul  = 1'b1;
            sonraki_gecerli = 1'b0;
          end else begin
            sonraki_durum   = BOSTA;
            sonraki_mesgul  = 1'b0;
            sonraki_gecerli = 1'b0;
          end
        end
        HESAPLA: begin
          if (sayac == SW'(N-1)) sonraki_durum = DUZELT;
        end
        DUZELT: begin
          sonraki_durum   = BITTI;
          sonraki_mesgul  = 1'b0;
          sonraki_gecerli = 1'b1;
        end
        default: sonraki_durum = BOSTA;
      endcase
    end
  end

  // State register with the registered busy/valid outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum           <= BOSTA;
      mesgul_o        <= 1'b0;
      sonuc_gecerli_o <= 1'b0;
    end else begin
      durum           <= sonraki_durum;
      mesgul_o        <= sonraki_mesgul;
      sonuc_gecerli_o <= sonraki_gecerli;
    end
  end

  // Operand latch, iterative steps and result load; frozen under stall or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac       <= '0;
      kalan_r     <= '0;
      bolum_r     <= '0;
      bolen_r     <= '0;
      kalan_sec_r <= 1'b0;
      neg_bolum_r <= 1'b0;
      neg_kalan_r <= 1'b0;
      sonuc_o     <= '0;
    end else if (!iptal_i && !durdur_i) begin
      if (kabul) begin
        kalan_sec_r <= kalan_istek;
        bolen_r     <= mutlak(bolen_i, isaretli);
        bolum_r     <= mutlak(bolunen_i, isaretli);
        kalan_r     <= '0;
        sayac       <= '0;
        neg_bolum_r <= isaretli && (bolunen_i[W-1] ^ bolen_i[W-1]);
        neg_kalan_r <= isaretli && bolunen_i[W-1];
        if (hizli) sonuc_o <= hizli_sonuc;
      end else if (durum == HESAPLA) begin
        kalan_r <= kalan_z[K];
        bolum_r <= bolum_z[K];
        sayac   <= sayac + SW'(1);
      end else if (durum == DUZELT) begin
        sonuc_o <= kalan_sec_r ? isaret_uygula(kalan_r[W-1:0], neg_kalan_r)
                               : isaret_uygula(bolum_r, neg_bolum_r);
      end
    end
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// Directed self-checking bench for bolme_birimi (32/1 and 16/2 instances).
module tb_bolme_birimi;
  import bolme_tanimlari::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i, durdur_i, iptal_i, blok_aktif_i;
  logic [1:0]  islem_kodu_i;
  logic [31:0] bolunen_i, bolen_i;
  logic        mesgul_o, sonuc_gecerli_o;
  logic [31:0] sonuc_o;

  logic        rst_16, durdur_16, iptal_16, blok_16;
  logic [1:0]  islem_16;
  logic [15:0] bolunen_16, bolen_16;
  logic        mesgul_16, gecerli_16;
  logic [15:0] sonuc_16;

  bolme_birimi #(.VERI_GENISLIGI(32), .ADIM_BASINA_BIT(1)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .durdur_i(durdur_i), .iptal_i(iptal_i),
    .blok_aktif_i(blok_aktif_i), .islem_kodu_i(islem_kodu_i),
    .bolunen_i(bolunen_i), .bolen_i(bolen_i), .mesgul_o(mesgul_o),
    .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_o(sonuc_o)
  );

  bolme_birimi #(.VERI_GENISLIGI(16), .ADIM_BASINA_BIT(2)) u_dut16 (
    .clk_i(clk_i), .rst_i(rst_16), .durdur_i(durdur_16), .iptal_i(iptal_16),
    .blok_aktif_i(blok_16), .islem_kodu_i(islem_16),
    .bolunen_i(bolunen_16), .bolen_i(bolen_16), .mesgul_o(mesgul_16),
    .sonuc_gecerli_o(gecerli_16), .sonuc_o(sonuc_16)
  );

  int karsilastirma = 0;
  int uyusmazlik    = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    karsilastirma++;
    if (gozlenen !== beklenen) begin
      uyusmazlik++;
      $display("FAIL %s: gozlenen=0x%08h beklenen=0x%08h", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic adim();
    @(posedge clk_i);
    #1;
  endtask

  task automatic baslat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    islem_kodu_i = op;
    bolunen_i    = a;
    bolen_i      = b;
    blok_aktif_i = 1'b1;
    adim();
    blok_aktif_i = 1'b0;
  endtask

  // Waits (bounded) for the valid pulse; leaves the bench in the BITTI cycle
  task automatic bekle(input string etiket, input logic [31:0] beklenen, input int gecikme, input int baslangic);
    int dongu;
    dongu = baslangic;
    while (!sonuc_gecerli_o && dongu < 80) begin
      adim();
      dongu++;
    end
    kontrol({etiket, "_gecikme"}, dongu, gecikme);
    kontrol(etiket, sonuc_o, beklenen);
  endtask

  task automatic islem(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] beklenen, input int gecikme, input string etiket);
    baslat(op, a, b);
    bekle(etiket, beklenen, gecikme, 1);
    adim();
  endtask

  initial begin
    rst_i = 1'b1; durdur_i = 1'b0; iptal_i = 1'b0; blok_aktif_i = 1'b0;
    islem_kodu_i = BOL_DIV; bolunen_i = '0; bolen_i = '0;
    rst_16 = 1'b1; durdur_16 = 1'b0; iptal_16 = 1'b0; blok_16 = 1'b0;
    islem_16 = BOL_DIVU; bolunen_16 = '0; bolen_16 = '0;

    #12;
    kontrol("rst_mesgul", {31'b0, mesgul_o}, 0);
    kontrol("rst_gecerli", {31'b0, sonuc_gecerli_o}, 0);
    kontrol("rst_sonuc", sonuc_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; rst_16 = 1'b0;
    adim();

    // DIVU 100/7 with a cycle-by-cycle busy/valid profile
    baslat(BOL_DIVU, 32'd100, 32'd7);
    for (int k = 1; k <= 34; k++) begin
      kontrol($sformatf("divu_mesgul_c%0d", k), {31'b0, mesgul_o}, {31'b0, (k <= 33)});
      kontrol($sformatf("divu_gecerli_c%0d", k), {31'b0, sonuc_gecerli_o}, {31'b0, (k == 34)});
      if (k < 34) adim();
    end
    kontrol("divu_100_7", sonuc_o, 32'd14);
    adim();
    kontrol("divu_gecerli_sonra", {31'b0, sonuc_gecerli_o}, 0);

    islem(BOL_REMU, 32'd100,        32'd7,          32'd2,          34, "remu_100_7");
    islem(BOL_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34, "div_m7_2");
    islem(BOL_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34, "rem_m7_2");
    islem(BOL_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          34, "rem_7_m2");
    islem(BOL_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34, "divu_min_ff");

    // Fast paths
    islem(BOL_DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1,  "divu_5_0");
    islem(BOL_REM,  32'd5,          32'd0,          32'd5,          1,  "rem_5_0");
    islem(BOL_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1,  "div_tasma");
    islem(BOL_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1,  "rem_tasma");

    // Stall for 5 cycles mid-HESAPLA
    baslat(BOL_DIVU, 32'd1000, 32'd7);
    repeat (9) adim();
    durdur_i = 1'b1;
    repeat (5) adim();
    kontrol("durdur_mesgul", {31'b0, mesgul_o}, 1);
    kontrol("durdur_gecerli", {31'b0, sonuc_gecerli_o}, 0);
    durdur_i = 1'b0;
    bekle("durdur_1000_7", 32'd142, 39, 15);
    adim();

    // Stall on the BITTI cycle holds the valid pulse
    baslat(BOL_DIVU, 32'd100, 32'd7);
    bekle("bitti_100_7", 32'd14, 34, 1);
    durdur_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adim();
      kontrol($sformatf("bitti_durdur_gecerli_%0d", k), {31'b0, sonuc_gecerli_o}, 1);
    end
    durdur_i = 1'b0;
    adim();
    kontrol("bitti_birakildi_gecerli", {31'b0, sonuc_gecerli_o}, 0);
    kontrol("bitti_birakildi_mesgul", {31'b0, mesgul_o}, 0);

    // Flush in cycle 10
    baslat(BOL_REMU, 32'd100, 32'd7);
    repeat (9) adim();
    iptal_i = 1'b1;
    adim();
    iptal_i = 1'b0;
    kontrol("iptal_mesgul", {31'b0, mesgul_o}, 0);
    kontrol("iptal_gecerli", {31'b0, sonuc_gecerli_o}, 0);
    kontrol("iptal_sonuc_korunur", sonuc_o, 32'd14);
    adim();
    kontrol("iptal_sonra_gecerli", {31'b0, sonuc_gecerli_o}, 0);

    // New start in cycle 12; a start request while busy must be ignored
    baslat(BOL_DIV, 32'hFFFFFF9C, 32'd7);
    repeat (2) adim();
    islem_kodu_i = BOL_DIVU; bolunen_i = 32'd5; bolen_i = 32'd0; blok_aktif_i = 1'b1;
    adim();
    blok_aktif_i = 1'b0;
    bekle("yeniden_div_m100_7", 32'hFFFFFFF2, 34, 4);

    // Back-to-back start from BITTI
    baslat(BOL_REM, 32'hFFFFFF9C, 32'd7);
    kontrol("b2b_mesgul", {31'b0, mesgul_o}, 1);
    kontrol("b2b_gecerli", {31'b0, sonuc_gecerli_o}, 0);
    bekle("b2b_rem_m100_7", 32'hFFFFFFFE, 34, 1);
    adim();

    // 16-bit, two bits per cycle
    begin
      int dongu;
      logic gorulen;
      islem_16 = BOL_DIVU; bolunen_16 = 16'hFFFF; bolen_16 = 16'd3; blok_16 = 1'b1;
      adim();
      blok_16 = 1'b0;
      dongu = 1;
      while (!gecerli_16 && dongu < 40) begin
        adim();
        dongu++;
      end
      kontrol("divu16_gecikme", dongu, 10);
      kontrol("divu16_ffff_3", {16'b0, sonuc_16}, 32'h5555);
      adim();

      islem_16 = BOL_DIVU; bolunen_16 = 16'h1234; bolen_16 = 16'd5; blok_16 = 1'b1;
      adim();
      blok_16 = 1'b0;
      repeat (3) adim();
      kontrol("rst16_once_mesgul", {31'b0, mesgul_16}, 1);
      #2 rst_16 = 1'b1;
      #1;
      kontrol("rst16_mesgul", {31'b0, mesgul_16}, 0);
      kontrol("rst16_gecerli", {31'b0, gecerli_16}, 0);
      kontrol("rst16_sonuc", {16'b0, sonuc_16}, 0);
      @(posedge clk_i); #1;
      rst_16 = 1'b0;
      gorulen = 1'b0;
      repeat (12) begin
        adim();
        if (gecerli_16) gorulen = 1'b1;
      end
      kontrol("rst16_sonuc_yok", {31'b0, gorulen}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, uyusmazlik);
    $finish;
  end

endmodule

// File: doc/bolme_birimi.md
Name: bolme_birimi

Overview:
- Parametrised, multi-cycle integer divider for RV32M DIV/DIVU/REM/REMU. It replaces the single-cycle combinational divide path in the execute-stage ALU.
- The ALU dispatches a divide op, then stalls the pipeline while mesgul_o is high. It collects the result on the sonuc_gecerli_o pulse.
- Adds what the combinational path lacks: configurable width, configurable bits-per-cycle, RISC-V-compliant divide-by-zero and overflow results, stall hold, and flush/cancel.

Parameters:
- VERI_GENISLIGI, 32: operand/result width in bits. Must be even and ≥8.
- ADIM_BASINA_BIT, 1: quotient bits produced per cycle (1, 2 or 4). VERI_GENISLIGI must be a multiple of it.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- durdur_i  in  1  pipeline stall. Freezes all internal state and outputs.
- iptal_i  in  1  flush. Aborts any operation in progress.
- blok_aktif_i  in  1  start request. Sampled only when the block is accepting.
- islem_kodu_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- bolunen_i  in  VERI_GENISLIGI  dividend.
- bolen_i  in  VERI_GENISLIGI  divisor.
- mesgul_o  out  1  high while an operation is in flight.
- sonuc_gecerli_o  out  1  result-valid pulse.
- sonuc_o  out  VERI_GENISLIGI  quotient or remainder, per the latched opcode.

Behaviour:
- Reset (async, rst_i=1):
  - State BOSTA.
  - mesgul_o=0, sonuc_gecerli_o=0, sonuc_o=0.
  - Counters and working registers cleared.
- States: BOSTA, HESAPLA, DUZELT, BITTI.
- Accepting state: BOSTA or BITTI, with durdur_i=0, iptal_i=0 and blok_aktif_i=1 at the clock edge.
  - The opcode and operands are latched at this edge.
  - Accepting in BITTI gives back-to-back operation.
- Normal path, acceptance in cycle 0:
  - Operands are converted to magnitudes. Signed conversion applies only for DIV/REM.
  - HESAPLA runs for cycles 1..N, where N = VERI_GENISLIGI/ADIM_BASINA_BIT.
  - Each cycle performs ADIM_BASINA_BIT restoring steps on the {remainder, quotient} shift register.
- DUZELT (cycle N+1): sign fix-up.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - sonuc_o is loaded at the end of this cycle.
- BITTI (cycle N+2):
  - sonuc_gecerli_o=1 for exactly one unstalled cycle.
  - Next state is BOSTA unless a new start is accepted.
- Latency: 34 cycles at the default parameters; N+2 in general.
- Fast path: checked at acceptance. The block goes directly to BITTI, with sonuc_gecerli_o high in cycle 1.
  - Divisor = 0: quotient = all ones (DIV/DIVU); remainder = dividend (REM/REMU).
  - Signed overflow (DIV/REM, dividend = 1 followed by zeros, divisor = all ones): quotient = dividend, remainder = 0.
- mesgul_o = 1 in HESAPLA and DUZELT, 0 in BOSTA and BITTI. Registered output.
- blok_aktif_i while mesgul_o=1 is ignored; it is neither queued nor an error.
- durdur_i=1: no state, counter or output changes.
  - In BITTI, sonuc_gecerli_o stays high until the first unstalled edge, so no pulse is lost.
  - durdur_i outranks acceptance.
- iptal_i=1 at an edge: state becomes BOSTA, sonuc_gecerli_o=0, sonuc_o unchanged. No result is produced for the aborted operation.
  - iptal_i outranks durdur_i and blok_aktif_i.
- sonuc_o holds its last value until the next DUZELT or fast-path load.
- Reset mid-operation: immediate return to the reset values; no residual result.
- Width rules:
  - Internal remainder register is VERI_GENISLIGI+1 bits, to hold the step subtraction sign.
  - Quotient register is VERI_GENISLIGI bits.
  - Magnitude of the most-negative value is handled without overflow, because the overflow case takes the fast path and the unsigned magnitude fits in VERI_GENISLIGI bits.

Decomposition:
- Shared package/header `bolme_tanimlari`:
  - Opcode constants BOL_DIV, BOL_DIVU, BOL_REM, BOL_REMU.
  - State encodings for BOSTA, HESAPLA, DUZELT, BITTI.
- Sub-module `bolme_adimi`:
  - Combinational, one restoring step: shift, trial-subtract, select, quotient bit.
  - Instantiated ADIM_BASINA_BIT times in a generate chain inside bolme_birimi.

Test Plan:
- DIVU 100/7 at defaults, accepted cycle 0 → mesgul_o high in cycles 1–33; sonuc_gecerli_o high in cycle 34 only; sonuc_o=14. Repeat with REMU → 2.
- Signed cases:
  - DIV −7/2 → 0xFFFFFFFD (−3).
  - REM −7/2 → 0xFFFFFFFF (−1).
  - REM 7/−2 → 1.
- Fast paths:
  - DIVU 5/0 → 0xFFFFFFFF, valid in cycle 1.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Stalls:
  - durdur_i high for 5 cycles mid-HESAPLA → result valid in cycle 39 with the correct value.
  - durdur_i high on the BITTI cycle → sonuc_gecerli_o stays high until durdur_i falls.
- iptal_i in cycle 10:
  - Next cycle is BOSTA, mesgul_o=0, no valid pulse, sonuc_o keeps its prior value.
  - A new start in cycle 12 completes normally.
  - A new start in the BITTI cycle is accepted back-to-back.
- VERI_GENISLIGI=16, ADIM_BASINA_BIT=2: DIVU 0xFFFF/3 → 0x5555 with valid in cycle 10. Async rst_i mid-operation clears all outputs immediately.
